// File: rtl/tile_accum_drain.sv
// Partial-tile accumulator: sums K partial NxN product tiles row by row, then
// drains the finished tile element by element with padding mask, ReLU and skip.
module tile_accum_drain #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_add_nums,
  input  logic [CNT_W-1:0]    cfg_t_tiles,
  input  logic [CNT_W-1:0]    cfg_w_tiles,
  input  logic [IDX_W-1:0]    cfg_t_last,
  input  logic [IDX_W-1:0]    cfg_w_last,
  input  logic                cfg_relu,
  input  logic                cfg_skip_pad,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_mask,
  output logic [IDX_W-1:0]    out_row,
  output logic [IDX_W-1:0]    out_col,
  output logic                out_tile_last,
  output logic                conv_done
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(N);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state, state_n;

  logic [CNT_W-1:0] k_num, t_num, w_num, k, t, w;
  logic [IDX_W-1:0] t_last_v, w_last_v, r, sr, sc, rows_v, cols_v;
  logic             relu_q, skip_q, pres, fin;
  logic [ACC_W-1:0] acc [N][N];
  logic [ACC_W-1:0] acc_nxt [N];
  logic [ACC_W:0]   lane_ext [N];
  logic [ACC_W:0]   sum [N];
  logic [ACC_W-1:0] cur;
  logic             beat, last_beat, adv, t_end, conv_last, cur_mask;
  logic             in_ready_d, conv_done_d;

  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (r == LAST_IDX) && (k == k_num - CNT_ONE);
  assign t_end     = (t == t_num - CNT_ONE);
  assign conv_last = t_end && (w == w_num - CNT_ONE);
  assign rows_v    = t_end ? t_last_v : FULL_IDX;
  assign cols_v    = (w == w_num - CNT_ONE) ? w_last_v : FULL_IDX;
  assign cur       = acc[sr[RW-1:0]][sc[RW-1:0]];
  assign cur_mask  = (sr < rows_v) && (sc < cols_v);
  // pres without out_valid means the presented element is a skipped pad
  assign adv       = pres && (!out_valid || out_ready);

  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      lane_ext[j] = {{(ACC_W + 1 - DATA_W){in_row[j*DATA_W + DATA_W - 1]}},
                     in_row[j*DATA_W +: DATA_W]};
      sum[j] = {acc[r[RW-1:0]][j][ACC_W-1], acc[r[RW-1:0]][j]} + lane_ext[j];
      if (k == '0)
        acc_nxt[j] = lane_ext[j][ACC_W-1:0];
      else if (sum[j][ACC_W] != sum[j][ACC_W-1])
        acc_nxt[j] = sum[j][ACC_W] ? ACC_MIN : ACC_MAX;
      else
        acc_nxt[j] = sum[j][ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start)     state_n = ACCUM;
      ACCUM:      if (last_beat) state_n = DRAIN;
      DRAIN:      if (fin)       state_n = conv_last ? DONE : ACCUM;
      default:                   state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_n == ACCUM);
    conv_done_d = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_num <= '0; t_num <= '0; w_num <= '0;
      t_last_v <= '0; w_last_v <= '0; relu_q <= 1'b0; skip_q <= 1'b0;
      k <= '0; t <= '0; w <= '0; r <= '0; sr <= '0; sc <= '0;
      pres <= 1'b0; fin <= 1'b0;
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++)
          acc[i][j] <= '0;
      in_ready <= 1'b0; conv_done <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_mask <= 1'b0;
      out_row <= '0; out_col <= '0; out_tile_last <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      conv_done <= conv_done_d;
      case (state)
        IDLE, DONE: if (start) begin
          k_num    <= (cfg_add_nums == '0) ? CNT_ONE : cfg_add_nums;
          t_num    <= (cfg_t_tiles == '0) ? CNT_ONE : cfg_t_tiles;
          w_num    <= (cfg_w_tiles == '0) ? CNT_ONE : cfg_w_tiles;
          t_last_v <= (cfg_t_last == '0) ? FULL_IDX : cfg_t_last;
          w_last_v <= (cfg_w_last == '0) ? FULL_IDX : cfg_w_last;
          relu_q   <= cfg_relu;
          skip_q   <= cfg_skip_pad;
          k <= '0; t <= '0; w <= '0; r <= '0;
        end
        ACCUM: if (beat) begin
          for (int unsigned j = 0; j < N; j++)
            acc[r[RW-1:0]][j] <= acc_nxt[j];
          if (r == LAST_IDX) begin
            r <= '0;
            k <= last_beat ? '0 : k + CNT_ONE;
          end else begin
            r <= r + IDX_ONE;
          end
          if (last_beat) begin
            sr <= '0; sc <= '0; pres <= 1'b0; fin <= 1'b0;
          end
        end
        DRAIN: begin
          if (fin) begin
            fin <= 1'b0;
            if (t_end) begin
              t <= '0;
              w <= w + CNT_ONE;
            end else begin
              t <= t + CNT_ONE;
            end
          end else if (!pres || adv) begin
            // the scan pointer always runs one element ahead of the output register
            if (pres && out_tile_last) begin
              pres <= 1'b0; fin <= 1'b0 | 1'b1;
              out_valid <= 1'b0; out_tile_last <= 1'b0;
            end else begin
              pres          <= 1'b1;
              out_valid     <= !skip_q || cur_mask;
              out_data      <= (relu_q && cur[ACC_W-1]) ? '0 : cur;
              out_mask      <= cur_mask;
              out_row       <= sr;
              out_col       <= sc;
              out_tile_last <= (sr == LAST_IDX) && (sc == LAST_IDX);
              if (sc == LAST_IDX) begin
                sc <= '0;
                sr <= sr + IDX_ONE;
              end else begin
                sc <= sc + IDX_ONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_accum_drain.sv
// Directed bench for tile_accum_drain (N=4, 8-bit data/accumulator).
module tb_tile_accum_drain;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 8;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = $clog2(N) + 1;

  logic clk = 1'b0;
  logic rst, start, cfg_relu, cfg_skip_pad, in_valid, in_ready;
  logic [CNT_W-1:0] cfg_add_nums, cfg_t_tiles, cfg_w_tiles;
  logic [IDX_W-1:0] cfg_t_last, cfg_w_last, out_row, out_col;
  logic [N*DATA_W-1:0] in_row;
  logic out_valid, out_ready, out_mask, out_tile_last, conv_done;
  logic [ACC_W-1:0] out_data;

  typedef struct { int data; int row; int col; int mask; int last; } elem_t;
  elem_t got[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tile_accum_drain #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_add_nums(cfg_add_nums), .cfg_t_tiles(cfg_t_tiles), .cfg_w_tiles(cfg_w_tiles),
    .cfg_t_last(cfg_t_last), .cfg_w_last(cfg_w_last),
    .cfg_relu(cfg_relu), .cfg_skip_pad(cfg_skip_pad),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_row(out_row), .out_col(out_col),
    .out_tile_last(out_tile_last), .conv_done(conv_done)
  );

  task automatic check_eq(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [N*DATA_W-1:0] mk_row(input int a, input int b, input int c, input int d);
    logic [N*DATA_W-1:0] v;
    v = {DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
    return v;
  endfunction

  function automatic int exp_val(input int kind, input int tile, input int r, input int c);
    case (kind)
      0: return c + 1;
      1: return 15;
      2: return tile * 16 + r * 4 + c;
      3: return (c < 2) ? 127 : -128;
      4: return (c < 2) ? 127 : 0;
      default: return (r + c - 2 > 0) ? r + c - 2 : 0;
    endcase
  endfunction

  task automatic start_conv(input int k, input int tt, input int ww, input int tl, input int wl,
                            input bit relu, input bit skip);
    @(negedge clk);
    cfg_add_nums = CNT_W'(k); cfg_t_tiles = CNT_W'(tt); cfg_w_tiles = CNT_W'(ww);
    cfg_t_last = IDX_W'(tl); cfg_w_last = IDX_W'(wl);
    cfg_relu = relu; cfg_skip_pad = skip; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_row(input logic [N*DATA_W-1:0] row, input bit hold);
    int n = 0;
    in_row = row; in_valid = 1'b1;
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    if (!in_ready) check_eq("in_ready_wait", int'(in_ready), 1);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input bit rnd, input int stop_after,
                       output int stall_bad, output int rdy_bad);
    elem_t prev, now;
    bit stalled = 1'b0;
    bit done = 1'b0;
    int cyc = 0;
    got.delete(); stall_bad = 0; rdy_bad = 0;
    while (!done && cyc < 400) begin
      now = '{int'($signed(out_data)), int'(out_row), int'(out_col), int'(out_mask), int'(out_tile_last)};
      if (stalled && (!out_valid || now != prev)) stall_bad++;
      if (in_ready) rdy_bad++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got.push_back(now);
        if (out_tile_last || got.size() == stop_after) done = 1'b1;
      end else if (!out_valid && out_tile_last) begin
        done = 1'b1;
      end
      stalled = out_valid && !out_ready;
      prev = now;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    check_eq({tag, "_drain_end"}, int'(done), 1);
  endtask

  task automatic check_full(input string tag, input int kind, input int tile, input int rv, input int cv);
    check_eq({tag, "_count"}, got.size(), 16);
    foreach (got[i]) begin
      int r = i / 4;
      int c = i % 4;
      check_eq($sformatf("%s_data%0d", tag, i), got[i].data, exp_val(kind, tile, r, c));
      check_eq($sformatf("%s_pos%0d", tag, i),
               got[i].row * 1000 + got[i].col * 100 + got[i].mask * 10 + got[i].last,
               r * 1000 + c * 100 + ((r < rv && c < cv) ? 10 : 0) + ((i == 15) ? 1 : 0));
    end
  endtask

  task automatic check_skip(input string tag, input int tile, input int rv, input int cv);
    check_eq({tag, "_count"}, got.size(), rv * cv);
    foreach (got[i]) begin
      int r = i / cv;
      int c = i % cv;
      check_eq($sformatf("%s_data%0d", tag, i), got[i].data, exp_val(2, tile, r, c));
      check_eq($sformatf("%s_pos%0d", tag, i),
               got[i].row * 1000 + got[i].col * 100 + got[i].mask * 10 + got[i].last,
               r * 1000 + c * 100 + 10 + ((r == 3 && c == 3) ? 1 : 0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sb, rb;
    int rvs[4] = '{4, 3, 4, 3};
    int cvs[4] = '{4, 4, 2, 2};
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
    cfg_add_nums = '0; cfg_t_tiles = '0; cfg_w_tiles = '0; cfg_t_last = '0; cfg_w_last = '0;
    cfg_relu = 1'b0; cfg_skip_pad = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_conv_done", int'(conv_done), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    rst = 1'b0;

    // basic tile, K=1
    start_conv(1, 1, 1, 0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) send_row(mk_row(1, 2, 3, 4), 1'b0);
    drain("t1", 1'b0, 0, sb, rb);
    check_full("t1", 0, 0, 4, 4);
    @(negedge clk);
    check_eq("t1_conv_done", int'(conv_done), 1);
    check_eq("t1_in_ready_done", int'(in_ready), 0);

    // K=3 with in_valid held high throughout
    start_conv(3, 1, 1, 0, 0, 1'b0, 1'b0);
    for (int b = 0; b < 12; b++) send_row(mk_row(5, 5, 5, 5), 1'b1);
    drain("t2", 1'b0, 0, sb, rb);
    in_valid = 1'b0;
    check_eq("t2_in_ready_in_drain", rb, 0);
    check_full("t2", 1, 0, 4, 4);

    // edge tiles T=2 W=2, with and without skip
    for (int s = 0; s < 2; s++) begin
      start_conv(1, 2, 2, 3, 2, 1'b0, s[0]);
      for (int i = 0; i < 4; i++) begin
        for (int r = 0; r < 4; r++)
          send_row(mk_row(i*16 + r*4, i*16 + r*4 + 1, i*16 + r*4 + 2, i*16 + r*4 + 3), 1'b0);
        drain($sformatf("t3s%0d_tile%0d", s, i), 1'b0, 0, sb, rb);
        if (s == 0) check_full($sformatf("t3_tile%0d", i), 2, i, rvs[i], cvs[i]);
        else        check_skip($sformatf("t3skip_tile%0d", i), i, rvs[i], cvs[i]);
      end
      @(negedge clk);
      check_eq($sformatf("t3s%0d_conv_done", s), int'(conv_done), 1);
    end

    // saturation, then with ReLU
    for (int m = 0; m < 2; m++) begin
      start_conv(2, 1, 1, 0, 0, m[0], 1'b0);
      for (int b = 0; b < 8; b++) send_row(mk_row(100, 100, -100, -100), 1'b0);
      drain($sformatf("t4m%0d", m), 1'b0, 0, sb, rb);
      check_full($sformatf("t4m%0d", m), 3 + m, 0, 4, 4);
    end

    // random backpressure
    start_conv(1, 1, 1, 0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) send_row(mk_row(1, 2, 3, 4), 1'b0);
    drain("t5", 1'b1, 0, sb, rb);
    check_eq("t5_stall_stable", sb, 0);
    check_full("t5", 0, 0, 4, 4);

    // reset mid-drain, then a fresh run
    start_conv(1, 1, 1, 0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) send_row(mk_row(9, 9, 9, 9), 1'b0);
    drain("t6a", 1'b0, 5, sb, rb);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_valid", int'(out_valid), 0);
    check_eq("t6_rst_in_ready", int'(in_ready), 0);
    check_eq("t6_rst_data", int'(out_data), 0);
    check_eq("t6_rst_pos", int'(out_row) * 100 + int'(out_col) * 10 + int'(out_mask), 0);
    check_eq("t6_rst_last_done", int'(out_tile_last) + int'(conv_done), 0);
    rst = 1'b0;
    start_conv(2, 1, 1, 0, 0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) send_row(mk_row(-2, -1, 0, 1), 1'b0);
    for (int r = 0; r < 4; r++) send_row(mk_row(r, r, r, r), 1'b0);
    drain("t6b", 1'b0, 0, sb, rb);
    check_full("t6b", 5, 0, 4, 4);
    @(negedge clk);
    check_eq("t6b_conv_done", int'(conv_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_accum_drain.md
# tile_accum_drain

Parametrised successor to the partial-tile accumulator in the img2col GEMM datapath. It sits between the N-wide systolic matrix multiplier and the result writer. It accumulates `cfg_add_nums` partial N×N product tiles, one row per beat, then drains the finished tile element by element over a ready/valid port. Each element carries a padding mask for edge tiles (last img2col-T tile and last kernel/W tile) and can pass through optional ReLU, saturation and padding-skip.

## Interface
Parameters:
- N, 8: tile dimension; one input beat is one row of N products
- DATA_W, 32: signed product width per lane
- ACC_W, 32: signed accumulator/output width, ACC_W ≥ DATA_W
- CNT_W, 16: width of tile-count configuration fields
- IDX_W, $clog2(N)+1: width of row/col indices and last-tile counts

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; samples all cfg_* and begins a convolution; honoured only in IDLE or DONE
- cfg_add_nums  in  CNT_W  partial tiles per output tile (K); 0 treated as 1
- cfg_t_tiles  in  CNT_W  T tiles per W tile (≥1)
- cfg_w_tiles  in  CNT_W  W tiles (≥1)
- cfg_t_last  in  IDX_W  valid rows in last T tile; 0 means N
- cfg_w_last  in  IDX_W  valid cols in last W tile; 0 means N
- cfg_relu  in  1  clamp negative outputs to 0
- cfg_skip_pad  in  1  suppress masked elements instead of emitting them
- in_valid  in  1  input row valid
- in_ready  out  1  high only in ACCUM
- in_row  in  N*DATA_W  lane j at bits [j*DATA_W +: DATA_W]
- out_valid  out  1  output element valid
- out_ready  in  1  consumer ready
- out_data  out  ACC_W  element value
- out_mask  out  1  1 = real element, 0 = padding
- out_row, out_col  out  IDX_W each  element position in tile
- out_tile_last  out  1  last element of the current tile
- conv_done  out  1  high in DONE

## Operation
- States: IDLE, ACCUM, DRAIN, DONE. Reset enters IDLE; all outputs 0; counters and accumulator array cleared.
- IDLE/DONE + start → ACCUM. Latch cfg; clear r (row), k (partial), t, w; conv_done falls.
- ACCUM, on in_valid&&in_ready:
  - lane j: acc[r][j] = (k==0) ? sext(in_row_j) : sat(acc[r][j] + sext(in_row_j)).
  - sat clamps to ACC_W signed min/max.
  - r wraps N-1→0 and increments k.
  - Beat with r==N-1, k==K-1 → DRAIN.
- DRAIN: row-major scan, (row,col) from (0,0) to (N-1,N-1).
  - rows_v = (t==T-1) ? (cfg_t_last==0 ? N : cfg_t_last) : N.
  - cols_v = (w==W-1) ? (cfg_w_last==0 ? N : cfg_w_last) : N.
  - out_mask = (row<rows_v)&&(col<cols_v).
  - out_data = relu ? max(acc,0) : acc.
  - cfg_skip_pad=0: every element presented with out_valid=1.
  - cfg_skip_pad=1: masked elements advance one per cycle with out_valid=0. out_tile_last still marks scan position (N-1,N-1); if that element is masked, the tile ends silently.
- End of tile: the last scan position is accepted, or skipped in skip mode.
  - t wraps at T-1 and increments w.
  - If t==T-1 and w==W-1 → DONE; else → ACCUM.
- DONE: conv_done=1, in_ready=0, out_valid=0 until start or rst.
- start in ACCUM/DRAIN is ignored. in_valid outside ACCUM is ignored; no data loss because in_ready=0.

## Timing
- All outputs registered.
- Input beat accepted at edge e: row write visible at e.
- Final beat of a tile at edge e: out_valid=1 with element (0,0) from e+1 (skip mode: first unmasked element may come later).
- Backpressure: while out_valid && !out_ready, out_data/mask/row/col/tile_last hold stable.
- Advance only on out_valid&&out_ready, or one per cycle on skipped elements.
- ACCUM throughput 1 row/cycle. DRAIN is N² cycles when out_ready is held high.
- Last drain accept at edge e: in_ready=1 from e+1 (ACCUM) or conv_done=1 from e+1 (DONE).
- rst mid-operation: next edge returns to IDLE with all outputs 0. The next start needs no extra flush.

## Test plan
- N=4, K=1, T=W=1, rows [1,2,3,4]×4, out_ready=1 → 16 elements, row-major, all mask=1, out_tile_last on the 16th, conv_done next cycle.
- N=4, K=3, each partial row all 5 → every out_data=15; in_ready=0 through the whole drain; no beat lost with in_valid held high.
- N=4, K=1, T=2, W=2, t_last=3, w_last=2: in tile (t=1,w=1), exactly 6 mask=1 elements (rows 0-2, cols 0-1). Repeat with skip_pad=1 → only those 6 have out_valid=1; tile order (0,0),(1,0),(0,1),(1,1).
- ACC_W=DATA_W=8, K=2, lanes 100+100 and −100+−100 → 127 and −128. With cfg_relu=1 → 127 and 0.
- Toggle out_ready randomly during drain → outputs stable while stalled; element sequence identical to the unstalled run.
- Assert rst during DRAIN element 5, then restart with a new cfg → outputs 0 the cycle after rst; second run bit-exact against the model.
